// File: rtl/pkt_meas_rec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pkt_meas_rec
// Purpose  : Per-packet measurement record generator. It watches the accepted
//            word stream of a module-header bus. For every complete packet it
//            builds one 64-bit record: {ts_hdr, byte_len, src_port, seq}.
//            Records are queued in a small FIFO and written into the
//            downstream payload FIFO. Records that find the queue full are
//            counted and dropped.
// Ports    : clk           - single clock
//            reset         - asynchronous, active-low reset
//            enable        - gates the start of new packets only
//            mon_data/ctrl - observed bus word
//            mon_wr        - observed word accepted this cycle
//            pld_fifo_din  - record at the queue head
//            pld_fifo_wr   - write strobe to the payload FIFO
//            pld_fifo_full - payload FIFO full
//            pkts_seen     - complete packets observed (wraps)
//            recs_dropped  - records lost to a full queue (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module pkt_meas_rec #(
  parameter int                    DATA_WIDTH       = 64,
  parameter int                    CTRL_WIDTH       = 8,
  parameter int                    WORD_WIDTH       = 64,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL         = 8'hFF,
  parameter int                    QUEUE_DEPTH_BITS = 2,
  // Timestamp value loaded by reset; normally zero.
  parameter logic [31:0]           TS_INIT          = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] mon_data,
  input  logic [CTRL_WIDTH-1:0] mon_ctrl,
  input  logic                  mon_wr,
  output logic [WORD_WIDTH-1:0] pld_fifo_din,
  output logic                  pld_fifo_wr,
  input  logic                  pld_fifo_full,
  output logic [31:0]           pkts_seen,
  output logic [15:0]           recs_dropped
);

  localparam int c_DEPTH = 1 << QUEUE_DEPTH_BITS;
  localparam logic [QUEUE_DEPTH_BITS:0] c_FULL_CNT = {1'b1, {QUEUE_DEPTH_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_WAIT_HDR = 3'b001,
    S_IN_HDRS  = 3'b010,
    S_IN_PKT   = 3'b100
  } state_t;

  state_t                      r_state;
  logic [31:0]                 r_ts;
  logic [31:0]                 r_ts_hdr;
  logic [15:0]                 r_byte_len;
  logic [7:0]                  r_src_port;
  logic [7:0]                  r_seq;
  logic [31:0]                 r_pkts_seen;
  logic [15:0]                 r_recs_dropped;

  logic [WORD_WIDTH-1:0]       r_mem [c_DEPTH];
  logic [QUEUE_DEPTH_BITS-1:0] r_wr_ptr;
  logic [QUEUE_DEPTH_BITS-1:0] r_rd_ptr;
  logic [QUEUE_DEPTH_BITS:0]   r_count;

  logic                        w_eop;
  logic                        w_pop;
  logic                        w_push_ok;
  logic                        w_drop;
  logic                        w_is_ioq;
  logic [WORD_WIDTH-1:0]       w_record;
  logic                        w_unused;

  // Only the low 24 bits of the IOQ header carry fields we record.
  assign w_unused  = ^mon_data[DATA_WIDTH-1:24];

  assign w_is_ioq  = (mon_ctrl == IOQ_CTRL);
  assign w_eop     = (r_state == S_IN_PKT) && mon_wr && (mon_ctrl != '0);
  assign w_pop     = (r_count != '0) && !pld_fifo_full;
  // When the queue is full, a push is still accepted if the head leaves in
  // the same cycle. In that case the new record lands in the slot being freed.
  assign w_push_ok = w_eop && ((r_count != c_FULL_CNT) || w_pop);
  assign w_drop    = w_eop && !w_push_ok;
  assign w_record  = {r_ts_hdr, r_byte_len, r_src_port, r_seq};

  assign pld_fifo_wr  = w_pop;
  assign pld_fifo_din = r_mem[r_rd_ptr];
  assign pkts_seen    = r_pkts_seen;
  assign recs_dropped = r_recs_dropped;

  // Free-running timestamp
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts <= TS_INIT;
    end else begin
      r_ts <= r_ts + 32'd1;
    end
  end

  // Packet-tracking FSM with the record fields and sequence counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT_HDR;
      r_ts_hdr    <= '0;
      r_byte_len  <= '0;
      r_src_port  <= '0;
      r_seq       <= '0;
      r_pkts_seen <= '0;
    end else begin
      case (r_state)
        S_WAIT_HDR: begin
          if (mon_wr && w_is_ioq && enable) begin
            r_ts_hdr   <= r_ts;
            r_byte_len <= mon_data[15:0];
            r_src_port <= mon_data[23:16];
            r_state    <= S_IN_HDRS;
          end
        end
        S_IN_HDRS: begin
          if (mon_wr) begin
            if (w_is_ioq) begin
              // A second IOQ header means the previous header had no data.
              // Restart the measurement from this header.
              r_ts_hdr   <= r_ts;
              r_byte_len <= mon_data[15:0];
              r_src_port <= mon_data[23:16];
            end else if (mon_ctrl == '0) begin
              r_state <= S_IN_PKT;
            end
          end
        end
        S_IN_PKT: begin
          if (w_eop) begin
            r_state     <= S_WAIT_HDR;
            r_seq       <= r_seq + 8'd1;
            r_pkts_seen <= r_pkts_seen + 32'd1;
          end
        end
        default: r_state <= S_WAIT_HDR;
      endcase
    end
  end

  // Record queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_record;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop counter (saturating)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_recs_dropped <= '0;
    end else if (w_drop && (r_recs_dropped != 16'hFFFF)) begin
      r_recs_dropped <= r_recs_dropped + 16'd1;
    end
  end

endmodule
`default_nettype wire
